// File: rtl/acc_pkg.sv
// Shared definitions for the instruction sequencer slice.
//   - op_code encodings
//   - sequencer state enumeration
//   - CU / adder select patterns (widest supported array; users slice to NUM_COL)
//   - op_is_legal(): true for every op_code the sequencer implements
package acc_pkg;

  typedef logic [4:0] op_t;

  localparam op_t OP_NOP       = 5'b00000;
  localparam op_t OP_LOAD      = 5'b00001;
  localparam op_t OP_READ      = 5'b00010;
  localparam op_t OP_DIST      = 5'b00011;
  localparam op_t OP_SORT_ASC  = 5'b00100;
  localparam op_t OP_SORT_DESC = 5'b00101;

  typedef enum logic [3:0] {
    IDLE,
    MLB_WR,
    MLB_RD,
    CU_SUB,
    CU_MUL,
    BACK_IN,
    ADDER,
    SORT,
    DONE
  } state_t;

  // Patterns sized for the largest supported column count; LSB is column 0.
  localparam int          SEL_PAT_MAX_W  = 64;
  localparam logic [63:0] SEL_CU_SUB_PAT = '0;
  localparam logic [63:0] SEL_CU_MUL_PAT = '1;
  localparam logic [63:0] SEL_ADDER_PAT  = {32{2'b10}};

  function automatic logic op_is_legal(input op_t op);
    return (op <= OP_SORT_DESC);
  endfunction

endpackage

// File: rtl/ins_sequencer_if.sv
// Instruction handshake bundle between an issuing master and ins_sequencer.
//   ins_valid  master->slave  instruction offered
//   ins_ready  slave->master  sequencer is idle and accepts
//   op_code    master->slave  5-bit operation
//   op_addr1   master->slave  read base address
//   op_addr2   master->slave  write base address
interface ins_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              ins_valid;
  logic              ins_ready;
  logic [4:0]        op_code;
  logic [ADDR_W-1:0] op_addr1;
  logic [ADDR_W-1:0] op_addr2;

  modport master (
    output ins_valid, op_code, op_addr1, op_addr2,
    input  ins_ready
  );

  modport slave (
    input  ins_valid, op_code, op_addr1, op_addr2,
    output ins_ready
  );
endinterface

// File: rtl/ins_seq_cnt.sv
// Modulo-N up-counter with enable and terminal-count flag.
//   clk, rst  clock, asynchronous active-low reset (count -> 0)
//   en        advance by one; wraps N-1 -> 0
//   cnt       current count
//   tc        count equals N-1 (independent of en)
module ins_seq_cnt #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ins_sequencer.sv
// Instruction sequencer: accepts one instruction at a time over the ins
// handshake and steps the MLB / CU / adder / sorter controls through it.
//   clk, rst          clock, asynchronous active-low reset
//   ins               instruction handshake (ins_sequencer_if.slave)
//   mlb_read_en/_write_en, mlb_addr, sel_pe   MLB transfer controls
//   col_index, sel_cu, sel_cu_go_back, sel_adder, is_save_cu_out,
//   sum_row_pe, sum_column_pe                 column distribution controls
//   sort_start, asce  sorter kick and direction (asce held between sorts)
//   done              one-cycle completion pulse
//   err_illegal       one-cycle pulse after an undefined op_code is accepted
// Optional macro INS_SEQ_PERF_CNT_EN adds busy_cycles (saturating count of
// non-IDLE cycles) and ins_count (wrapping count of accepted instructions).
module ins_sequencer
  import acc_pkg::*;
#(
  parameter int NUM_PE  = 32,
  parameter int NUM_COL = 8,
  parameter int ADDR_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  ins_sequencer_if.slave             ins,
  output logic                       mlb_read_en,
  output logic                       mlb_write_en,
  output logic [ADDR_W-1:0]          mlb_addr,
  output logic [$clog2(NUM_PE)-1:0]  sel_pe,
  output logic [$clog2(NUM_COL)-1:0] col_index,
  output logic [NUM_COL-1:0]         sel_cu,
  output logic [NUM_COL-1:0]         sel_cu_go_back,
  output logic [NUM_COL-1:0]         sel_adder,
  output logic [NUM_COL/2-1:0]       is_save_cu_out,
  output logic [1:0]                 sum_row_pe,
  output logic [1:0]                 sum_column_pe,
  output logic                       sort_start,
  output logic                       asce,
  output logic                       done,
  output logic                       err_illegal
`ifdef INS_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                busy_cycles,
  output logic [15:0]                ins_count
`endif
);

  localparam int PE_W  = $clog2(NUM_PE);
  localparam int COL_W = $clog2(NUM_COL);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic              err_q;
  logic              accept;
  logic              pe_en, pe_tc;
  logic              col_en, col_tc;
  logic [PE_W-1:0]   pe_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic              in_dist;

  assign ins.ins_ready = (state == IDLE);
  assign accept        = ins.ins_valid && (state == IDLE);

  ins_seq_cnt #(.N(NUM_PE)) u_pe_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pe_en),
    .cnt (pe_cnt),
    .tc  (pe_tc)
  );

  ins_seq_cnt #(.N(NUM_COL)) u_col_cnt (
    .clk (clk),
    .rst (rst),
    .en  (col_en),
    .cnt (col_cnt),
    .tc  (col_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      err_q   <= 1'b0;
      asce    <= 1'b1;
    end else begin
      state <= state_n;
      err_q <= accept && !op_is_legal(ins.op_code);
      if (accept) begin
        addr1_q <= ins.op_addr1;
        addr2_q <= ins.op_addr2;
        if (ins.op_code == OP_SORT_ASC) begin
          asce <= 1'b1;
        end else if (ins.op_code == OP_SORT_DESC) begin
          asce <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    pe_en   = 1'b0;
    col_en  = 1'b0;
    case (state)
      IDLE: begin
        if (ins.ins_valid) begin
          case (ins.op_code)
            OP_NOP:       state_n = DONE;
            OP_LOAD:      state_n = MLB_WR;
            OP_READ:      state_n = MLB_RD;
            OP_DIST:      state_n = CU_SUB;
            OP_SORT_ASC,
            OP_SORT_DESC: state_n = SORT;
            default:      state_n = IDLE;
          endcase
        end
      end
      MLB_WR, MLB_RD: begin
        pe_en = 1'b1;
        if (pe_tc) state_n = DONE;
      end
      CU_SUB:  state_n = CU_MUL;
      CU_MUL:  state_n = BACK_IN;
      BACK_IN: state_n = ADDER;
      ADDER: begin
        // Column counter wraps to 0 on the last column, leaving it clean for
        // the next instruction.
        col_en  = 1'b1;
        state_n = col_tc ? DONE : CU_SUB;
      end
      SORT:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded only from registered state, counters and latched
  // operands, so op_code has no path to them.
  assign in_dist = (state == CU_SUB) || (state == CU_MUL) ||
                   (state == BACK_IN) || (state == ADDER);

  always_comb begin
    mlb_write_en   = (state == MLB_WR);
    mlb_read_en    = (state == MLB_RD);
    mlb_addr       = '0;
    if (state == MLB_WR) mlb_addr = addr2_q + ADDR_W'(pe_cnt);
    if (state == MLB_RD) mlb_addr = addr1_q + ADDR_W'(pe_cnt);
    sel_pe         = pe_cnt;
    col_index      = col_cnt;
    sel_cu         = '0;
    if (state == CU_SUB) sel_cu = SEL_CU_SUB_PAT[NUM_COL-1:0];
    if (state == CU_MUL) sel_cu = SEL_CU_MUL_PAT[NUM_COL-1:0];
    sel_cu_go_back = (state == BACK_IN) ? '1 : '0;
    is_save_cu_out = (state == BACK_IN) ? '1 : '0;
    sel_adder      = (state == ADDER) ? SEL_ADDER_PAT[NUM_COL-1:0] : '0;
    sum_row_pe     = in_dist ? 2'b10 : 2'b00;
    sum_column_pe  = in_dist ? 2'b10 : 2'b00;
    sort_start     = (state == SORT);
    done           = (state == DONE);
    err_illegal    = err_q;
  end

`ifdef INS_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cycles <= '0;
      ins_count   <= '0;
    end else begin
      if (state != IDLE && busy_cycles != '1) busy_cycles <= busy_cycles + 1'b1;
      if (accept) ins_count <= ins_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_sequencer.sv
module tb_ins_sequencer;
  import acc_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [4:0]  pe;
    logic [2:0]  col;
    logic [7:0]  cu;
    logic [7:0]  gb;
    logic [7:0]  add;
    logic [3:0]  save;
    logic [1:0]  srow;
    logic [1:0]  scol;
    logic        ss;
    logic        asce;
    logic        done;
    logic        err;
    logic        ready;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_sequencer_if #(.ADDR_W(16)) ins_bus ();

  logic        mlb_read_en, mlb_write_en;
  logic [15:0] mlb_addr;
  logic [4:0]  sel_pe;
  logic [2:0]  col_index;
  logic [7:0]  sel_cu, sel_cu_go_back, sel_adder;
  logic [3:0]  is_save_cu_out;
  logic [1:0]  sum_row_pe, sum_column_pe;
  logic        sort_start, asce, done, err_illegal;
`ifdef INS_SEQ_PERF_CNT_EN
  logic [31:0] busy_cycles;
  logic [15:0] ins_count;
`endif

  ins_sequencer #(.NUM_PE(32), .NUM_COL(8), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ins            (ins_bus),
    .mlb_read_en    (mlb_read_en),
    .mlb_write_en   (mlb_write_en),
    .mlb_addr       (mlb_addr),
    .sel_pe         (sel_pe),
    .col_index      (col_index),
    .sel_cu         (sel_cu),
    .sel_cu_go_back (sel_cu_go_back),
    .sel_adder      (sel_adder),
    .is_save_cu_out (is_save_cu_out),
    .sum_row_pe     (sum_row_pe),
    .sum_column_pe  (sum_column_pe),
    .sort_start     (sort_start),
    .asce           (asce),
    .done           (done),
    .err_illegal    (err_illegal)
`ifdef INS_SEQ_PERF_CNT_EN
    ,
    .busy_cycles    (busy_cycles),
    .ins_count      (ins_count)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  obs_t        exp_q[$];
  logic        m_asce = 1'b1;
  int unsigned m_busy = 0;
  int unsigned m_ins  = 0;

  function automatic obs_t sample();
    obs_t s;
    s.rd    = mlb_read_en;
    s.wr    = mlb_write_en;
    s.addr  = mlb_addr;
    s.pe    = sel_pe;
    s.col   = col_index;
    s.cu    = sel_cu;
    s.gb    = sel_cu_go_back;
    s.add   = sel_adder;
    s.save  = is_save_cu_out;
    s.srow  = sum_row_pe;
    s.scol  = sum_column_pe;
    s.ss    = sort_start;
    s.asce  = asce;
    s.done  = done;
    s.err   = err_illegal;
    s.ready = ins_bus.ins_ready;
    return s;
  endfunction

  function automatic obs_t blank();
    obs_t e = '0;
    e.asce = m_asce;
    return e;
  endfunction

  // Reference: expected outputs for each cycle after acceptance, ending with
  // the first idle cycle.
  task automatic model_instr(input logic [4:0] op, input logic [15:0] a1, input logic [15:0] a2);
    obs_t e;
    exp_q.delete();
    m_ins++;
    if (op == OP_SORT_ASC)  m_asce = 1'b1;
    if (op == OP_SORT_DESC) m_asce = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LOAD, OP_READ:
        for (int i = 0; i < 32; i++) begin
          e = blank();
          if (op == OP_LOAD) begin e.wr = 1'b1; e.addr = a2 + 16'(i); end
          else               begin e.rd = 1'b1; e.addr = a1 + 16'(i); end
          e.pe = 5'(i);
          exp_q.push_back(e);
        end
      OP_DIST:
        for (int k = 0; k < 32; k++) begin
          e = blank();
          e.col  = 3'(k / 4);
          e.srow = 2'b10;
          e.scol = 2'b10;
          case (k % 4)
            1:       e.cu = 8'hFF;
            2:       begin e.gb = 8'hFF; e.save = 4'hF; end
            3:       e.add = 8'hAA;
            default: ;
          endcase
          exp_q.push_back(e);
        end
      OP_SORT_ASC, OP_SORT_DESC: begin
        e = blank(); e.ss = 1'b1; exp_q.push_back(e);
      end
      default: begin
        e = blank(); e.err = 1'b1; e.ready = 1'b1; exp_q.push_back(e);
      end
    endcase
    if (op <= OP_SORT_DESC) begin
      e = blank(); e.done = 1'b1; exp_q.push_back(e);
      m_busy += exp_q.size();
    end
    e = blank(); e.ready = 1'b1; exp_q.push_back(e);
  endtask

  // Offer an instruction while idle; returns #1 after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [15:0] a1, input logic [15:0] a2, input bit hold);
    ins_bus.ins_valid = 1'b1;
    ins_bus.op_code   = op;
    ins_bus.op_addr1  = a1;
    ins_bus.op_addr2  = a2;
    model_instr(op, a1, a2);
    @(posedge clk); #1;
    if (!hold) ins_bus.ins_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    o = sample(); o.ready = 1'b1;
    m_asce = 1'b1; m_busy = 0; m_ins = 0;
    e = blank(); e.ready = 1'b1;
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_async got=%h exp=%h", o, e); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    o = sample();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", o, e); end
`ifdef INS_SEQ_PERF_CNT_EN
    checks++;
    if (busy_cycles !== 32'd0 || ins_count !== 16'd0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", busy_cycles, ins_count);
    end
`endif
  endtask

  task automatic test_load();
    obs_t o;
    issue(OP_LOAD, 16'h0000, 16'h0100, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL load[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_read_wrap();
    obs_t o;
    issue(OP_READ, 16'hFFF0, 16'h1234, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL read_wrap[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_dist();
    obs_t o;
    issue(OP_DIST, 16'($urandom), 16'($urandom), 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL dist[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   pulses = 0;
    issue(OP_SORT_DESC, 16'h0, 16'h0, 1'b1);
    ins_bus.op_code = OP_SORT_ASC;
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      pulses += int'(o.ss);
      if (o !== exp_q[i]) begin errors++; $display("FAIL b2b_desc[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
    issue(OP_SORT_ASC, 16'h0, 16'h0, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      pulses += int'(o.ss);
      if (o !== exp_q[i]) begin errors++; $display("FAIL b2b_asc[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_illegal();
    obs_t o;
    issue(5'b11111, 16'h0, 16'h0, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL illegal[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
`ifdef INS_SEQ_PERF_CNT_EN
    checks++;
    if (ins_count !== 16'(m_ins)) begin
      errors++; $display("FAIL illegal_ins_count got=%0d exp=%0d", ins_count, m_ins);
    end
`endif
  endtask

  task automatic test_nop();
    obs_t o;
    issue(OP_NOP, 16'h0, 16'h0, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL nop[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o, e;
    issue(OP_LOAD, 16'h0, 16'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL abort_pre[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
    #2 rst = 1'b0;
    #1;
    m_asce = 1'b1; m_busy = 0; m_ins = 0;
    e = blank(); e.ready = 1'b1;
    o = sample(); o.ready = 1'b1; checks++;
    if (o !== e) begin errors++; $display("FAIL abort_async got=%h exp=%h", o, e); end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL abort_idle[%0d] got=%h exp=%h", i, o, e); end
    end
    issue(OP_READ, 16'($urandom), 16'h0, 1'b0);
    foreach (exp_q[i]) begin
      if (i > 0) begin @(posedge clk); #1; end
      o = sample(); checks++;
      if (o !== exp_q[i]) begin errors++; $display("FAIL abort_read[%0d] got=%h exp=%h", i, o, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [4:0]  op;
    int unsigned r;
    for (int n = 0; n < 14; n++) begin
      r  = $urandom_range(0, 7);
      op = (r < 6) ? 5'(r) : 5'($urandom_range(6, 31));
      issue(op, 16'($urandom), 16'($urandom), 1'b0);
      foreach (exp_q[i]) begin
        if (i > 0) begin @(posedge clk); #1; end
        o = sample(); checks++;
        if (o !== exp_q[i]) begin
          errors++; $display("FAIL random op=%0d [%0d] got=%h exp=%h", op, i, o, exp_q[i]);
        end
      end
    end
`ifdef INS_SEQ_PERF_CNT_EN
    checks++;
    if (busy_cycles !== m_busy || ins_count !== 16'(m_ins)) begin
      errors++; $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d", busy_cycles, ins_count, m_busy, m_ins);
    end
`endif
  endtask

  initial begin
    ins_bus.ins_valid = 1'b0;
    ins_bus.op_code   = '0;
    ins_bus.op_addr1  = '0;
    ins_bus.op_addr2  = '0;
    test_reset();
    test_load();
    test_read_wrap();
    test_dist();
    test_back_to_back();
    test_illegal();
    test_nop();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ins_sequencer.md
INS_SEQUENCER -- requirements
Module: ins_sequencer

Interface
REQ-001 SHALL have parameter NUM_PE, default 32, number of PEs addressed by MLB transfers (power of 2, >=2).
REQ-002 SHALL have parameter NUM_COL, default 8, number of PE-array columns (even, >=2).
REQ-003 SHALL have parameter ADDR_W, default 16, operand address width.
REQ-004 Ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 Ports: ins_valid  in  1  instruction offered; ins_ready  out  1  sequencer accepts instruction.
REQ-006 Ports: op_code  in  5  operation; op_addr1  in  ADDR_W  read base address; op_addr2  in  ADDR_W  write base address.
REQ-007 Ports: mlb_read_en  out  1; mlb_write_en  out  1; mlb_addr  out  ADDR_W  current MLB address; sel_pe  out  clog2(NUM_PE)  current PE.
REQ-008 Ports: col_index  out  clog2(NUM_COL); sel_cu, sel_cu_go_back, sel_adder  out  NUM_COL each; is_save_cu_out  out  NUM_COL/2; sum_row_pe, sum_column_pe  out  2 each.
REQ-009 Ports: sort_start  out  1  one-cycle pulse; asce  out  1  sort direction; done  out  1  one-cycle completion pulse; err_illegal  out  1  one-cycle pulse on undefined op_code.

Function
REQ-010 Handshake: instruction accepted on rising clk when ins_valid && ins_ready; ins_ready SHALL be 1 only in IDLE; op_code/addresses latched at acceptance.
REQ-011 States SHALL be IDLE, MLB_WR, MLB_RD, CU_SUB, CU_MUL, BACK_IN, ADDER, SORT, DONE.
REQ-012 op 5'b00001 (LOAD): MLB_WR for exactly NUM_PE cycles, mlb_write_en=1, sel_pe 0..NUM_PE-1, mlb_addr=op_addr2+sel_pe (mod 2^ADDR_W), then DONE.
REQ-013 op 5'b00010 (READ): MLB_RD identical timing with mlb_read_en=1, mlb_addr=op_addr1+sel_pe, then DONE.
REQ-014 op 5'b00011 (DIST): per column, one cycle each CU_SUB (sel_cu=all 0), CU_MUL (sel_cu=all 1), BACK_IN (is_save_cu_out=all 1, sel_cu_go_back=all 1), ADDER (sel_adder=alternating 1010..., LSB 0); sum_row_pe=sum_column_pe=2'b10 throughout.
REQ-015 DIST: col_index increments leaving ADDER; after column NUM_COL-1 goes to DONE with col_index wrapping to 0; total 4*NUM_COL cycles.
REQ-016 op 5'b00100 (SORT_ASC) / 5'b00101 (SORT_DESC): one SORT cycle, sort_start=1, asce=1/0 held until next sort, then DONE.
REQ-017 DONE SHALL last one cycle with done=1, then IDLE; all enables/selects return to 0 in DONE and IDLE.
REQ-018 Undefined op_code: accepted, err_illegal pulses on next cycle, state stays IDLE, no done.
REQ-019 Outputs SHALL be registered (driven from state/counters, no combinational path from op_code to outputs).
REQ-020 ins_valid with op_code 5'b00000 SHALL be treated as NOP: done pulses next cycle.

Reset
REQ-021 rst low SHALL immediately force IDLE, all counters 0, all outputs 0 except ins_ready=1 after release; asce=1.
REQ-022 Reset mid-instruction SHALL abort it with no done pulse; next accepted instruction starts from sel_pe=0/col_index=0.

Configuration
REQ-023 Macro INS_SEQ_PERF_CNT_EN defined: adds outputs busy_cycles (32 bits, counts non-IDLE cycles, saturating, reset 0) and ins_count (16 bits, counts accepted instructions, wrapping); undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-024 Shared package acc_pkg SHALL hold op_code constants, state enumeration and sel_cu pattern constants.
REQ-025 One sub-module natural: ins_seq_cnt, a generic modulo-N up-counter with enable and terminal-count flag, instanced for sel_pe and col_index.

Verification
REQ-026 LOAD op_addr2=16'h0100, NUM_PE=32 -> mlb_write_en high 32 cycles, mlb_addr 0x0100..0x011F, done one cycle later, ins_ready low throughout.
REQ-027 READ op_addr1=16'hFFF0 -> mlb_addr wraps 0xFFF0..0x000F, mlb_read_en 32 cycles.
REQ-028 DIST, NUM_COL=8 -> 32 busy cycles, sel_cu 00/FF per column, sel_adder=8'hAA in ADDER, col_index 0..7 then 0, done once.
REQ-029 SORT_DESC then SORT_ASC back-to-back with ins_valid held -> sort_start pulses twice, asce 0 then 1, second accepted only after first done.
REQ-030 rst asserted in cycle 10 of LOAD -> outputs 0 asynchronously, no done; subsequent READ starts at sel_pe=0.
REQ-031 op_code 5'b11111 -> err_illegal single pulse, no done; with INS_SEQ_PERF_CNT_EN, ins_count increments by 1.
